// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-mode codes and the
// stop-bit selector, used by both the RX and TX sides.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [31:0] PAR_ZERO = 32'd0;
    localparam logic [31:0] PAR_ONE  = 32'd1;
    localparam logic [31:0] PAR_ODD  = 32'd2;
    localparam logic [31:0] PAR_EVEN = 32'd3;

    localparam logic [31:0] STOP_TWO = 32'd2;

    // Unknown mode codes fall back to a constant-0 parity slot.
    function automatic logic parity_bit(input logic [7:0] data, input logic [31:0] mode);
        case (mode)
            PAR_ONE:  parity_bit = 1'b1;
            PAR_ODD:  parity_bit = ~^data;
            PAR_EVEN: parity_bit = ^data;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the asynchronous serial line plus a falling-edge strobe.
// Flops reset to 1 so an idle line never produces a spurious edge after reset.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_line,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_last <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_line = r_sync[SYNC_STAGES-1];
    assign o_fall = r_last & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver with an AXI-Stream style byte output and single-cycle error pulses.
// Define AXIS_UART_RX_PARITY_CHECK_EN to check the parity slot; otherwise it is sampled and ignored.
module axis_uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [7:0]  maxis_data_o,
    output logic        maxis_tvalid_o,
    input  logic        maxis_tready_i,
    input  logic [31:0] delitel,
    input  logic [31:0] stop_bit_num,
    input  logic [31:0] parity_bit_mode,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    logic        w_line;
    logic        w_fall;
    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [32:0] r_cnt;
    logic [32:0] w_target;
    logic [31:0] r_div;
    logic        r_two_stop;
    logic [2:0]  r_bitcnt;
    logic        r_stopcnt;
    logic [7:0]  r_shift;
    logic        w_hit;
    logic        w_good;
    logic        w_ferr;
    logic        w_perr;
    logic        w_par_bad;
    logic        w_load;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rx   (uart_rx),
        .o_line (w_line),
        .o_fall (w_fall)
    );

    // The start bit is sampled half a period in; every later sample is a full period on.
    assign w_target = (r_state == RX_START) ? {1'b0, (r_div >> 1)} : {1'b0, r_div};
    assign w_hit    = (r_state != RX_IDLE) && (r_cnt == w_target);

`ifdef AXIS_UART_RX_PARITY_CHECK_EN
    logic [31:0] r_pmode;
    logic        r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmode <= '0;
            r_par   <= 1'b0;
        end else begin
            if (r_state == RX_IDLE && w_fall)
                r_pmode <= parity_bit_mode;
            if (r_state == RX_PARITY && w_hit)
                r_par <= w_line;
        end
    end

    assign w_par_bad = (r_par != parity_bit(r_shift, r_pmode));
`else
    logic w_unused_pmode;
    assign w_unused_pmode = ^parity_bit_mode;
    assign w_par_bad      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= RX_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_ferr      = 1'b0;
        w_perr      = 1'b0;
        case (r_state)
            RX_IDLE:   if (w_fall) w_state_nxt = RX_START;
            RX_START:  if (w_hit) w_state_nxt = w_line ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_hit && r_bitcnt == 3'd7) w_state_nxt = RX_PARITY;
            RX_PARITY: if (w_hit) w_state_nxt = RX_STOP;
            RX_STOP: begin
                if (w_hit) begin
                    if (!w_line) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else if (!r_two_stop || r_stopcnt) begin
                        w_state_nxt = RX_IDLE;
                        w_perr      = w_par_bad;
                        w_good      = ~w_par_bad;
                    end
                end
            end
            default:   w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_two_stop <= 1'b0;
            r_bitcnt   <= '0;
            r_stopcnt  <= 1'b0;
            r_shift    <= '0;
        end else if (r_state == RX_IDLE) begin
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            if (w_fall) begin
                r_div      <= delitel;
                r_two_stop <= (stop_bit_num == STOP_TWO);
            end
        end else begin
            r_cnt <= w_hit ? 33'd0 : r_cnt + 33'd1;
            if (w_hit && r_state == RX_DATA) begin
                r_shift  <= {w_line, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_hit && r_state == RX_STOP)
                r_stopcnt <= 1'b1;
        end
    end

    // A held byte is never overwritten unless it is being consumed in the same cycle.
    assign w_load = w_good && !(maxis_tvalid_o && !maxis_tready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxis_data_o   <= 8'h00;
            maxis_tvalid_o <= 1'b0;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            parity_err_o <= w_perr;
            frame_err_o  <= w_ferr;
            overrun_o    <= w_good && maxis_tvalid_o && !maxis_tready_i;
            if (w_load) begin
                maxis_data_o   <= r_shift;
                maxis_tvalid_o <= 1'b1;
            end else if (maxis_tvalid_o && maxis_tready_i) begin
                maxis_tvalid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Scoreboard bench for axis_uart_rx: serial frames are generated by a behavioural
// transmitter, the expected outcome of each frame is queued, and a monitor checks DUT outputs.
module tb_axis_uart_rx;

    localparam int EV_PERR = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVR  = 3;

`ifdef AXIS_UART_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic [7:0]  data_o;
    logic        tvalid;
    logic        tready;
    logic [31:0] delitel;
    logic [31:0] stop_bit_num;
    logic [31:0] parity_bit_mode;
    logic        perr_o;
    logic        ferr_o;
    logic        ovr_o;

    int          n_checks;
    int          n_pass;
    logic [7:0]  q_byte[$];
    int          q_evt[$];
    bit          stall_mode;
    bit          m_full;
    bit          rand_ready;
    bit          prev_stall;
    logic [7:0]  prev_data;

    axis_uart_rx #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uart_rx         (uart_rx),
        .maxis_data_o    (data_o),
        .maxis_tvalid_o  (tvalid),
        .maxis_tready_i  (tready),
        .delitel         (delitel),
        .stop_bit_num    (stop_bit_num),
        .parity_bit_mode (parity_bit_mode),
        .parity_err_o    (perr_o),
        .frame_err_o     (ferr_o),
        .overrun_o       (ovr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void check_evt(input int ev, input string name);
        if (q_evt.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got unexpected pulse, expected none", name);
        end else begin
            chk(name, ev, q_evt.pop_front());
        end
    endfunction

    // Monitor: sampled mid-cycle, after the stimulus edge has settled
    initial begin
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold_valid", {31'd0, tvalid}, 32'd1);
                    chk("stall_hold_data", {24'd0, data_o}, {24'd0, prev_data});
                end
                if (tvalid && tready) begin
                    if (q_byte.size() == 0) begin
                        n_checks++;
                        $display("FAIL byte: got unexpected 0x%0h, expected none", data_o);
                    end else begin
                        chk("byte", {24'd0, data_o}, {24'd0, q_byte.pop_front()});
                    end
                end
                if (perr_o) check_evt(EV_PERR, "parity_err_pulse");
                if (ferr_o) check_evt(EV_FERR, "frame_err_pulse");
                if (ovr_o)  check_evt(EV_OVR, "overrun_pulse");
                prev_stall = tvalid && !tready;
                prev_data  = data_o;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic b, input int n);
        uart_rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(1'b1, n);
    endtask

    // Behavioural transmitter plus reference outcome of the frame
    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input logic s2,
                              input logic [31:0] div, input logic [31:0] snum, input logic [31:0] mode);
        int   ones;
        int   per;
        bit   two;
        logic ep;
        delitel         = div;
        stop_bit_num    = snum;
        parity_bit_mode = mode;
        per  = int'(div) + 1;
        two  = (snum == 32'd2);
        ones = $countones(d);
        case (mode)
            32'd0:   ep = 1'b0;
            32'd1:   ep = 1'b1;
            32'd2:   ep = (ones % 2 == 0);
            32'd3:   ep = (ones % 2 == 1);
            default: ep = 1'b0;
        endcase
        if (!s1 || (two && !s2))
            q_evt.push_back(EV_FERR);
        else if (PCHK && par != ep)
            q_evt.push_back(EV_PERR);
        else if (m_full)
            q_evt.push_back(EV_OVR);
        else begin
            q_byte.push_back(d);
            if (stall_mode) m_full = 1'b1;
        end
        hold(1'b0, per);
        for (int i = 0; i < 8; i++) hold(d[i], per);
        hold(par, per);
        hold(s1, per);
        if (two) hold(s2, per);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        uart_rx = 1'b1; tready = 1'b1; rst_n = 1'b0;
        delitel = 32'd15; stop_bit_num = 32'd1; parity_bit_mode = 32'd0;
        stall_mode = 1'b0; m_full = 1'b0; rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", {24'd0, data_o}, 32'd0);
        chk("reset_tvalid", {31'd0, tvalid}, 32'd0);
        chk("reset_perr", {31'd0, perr_o}, 32'd0);
        chk("reset_ferr", {31'd0, ferr_o}, 32'd0);
        chk("reset_ovr", {31'd0, ovr_o}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Basic byte, then parity mismatch, then a bad second stop with the line held low
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 32'd15, 32'd1, 32'd0);
        idle(20);
        send_frame(8'h07, 1'b0, 1'b1, 1'b1, 32'd15, 32'd1, 32'd3);
        idle(20);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 32'd15, 32'd2, 32'd0);
        hold(1'b0, 100);
        idle(20);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 32'd15, 32'd2, 32'd0);
        idle(20);

        // Stalled output: second frame overruns, held byte survives
        tready = 1'b0; stall_mode = 1'b1;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 32'd15, 32'd1, 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 32'd15, 32'd1, 32'd0);
        idle(30);
        chk("overrun_held_data", {24'd0, data_o}, 32'h11);
        chk("overrun_held_valid", {31'd0, tvalid}, 32'd1);
        stall_mode = 1'b0; m_full = 1'b0; tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("tvalid_drop", {31'd0, tvalid}, 32'd0);

        // Short glitch, then reset in the middle of the data bits
        hold(1'b0, 3);
        idle(40);
        hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 16); hold(1'b1, 8);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mid_tvalid", {31'd0, tvalid}, 32'd0);
        chk("reset_mid_data", {24'd0, data_o}, 32'd0);
        rst_n = 1'b1;
        idle(20);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 32'd15, 32'd1, 32'd0);
        idle(20);

        // Random mix of modes, stop settings, parity and stop-bit errors
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0]  d;
            logic [31:0] md;
            logic [31:0] sn;
            logic        p;
            logic        a;
            logic        b;
            d  = 8'($urandom);
            md = $urandom_range(0, 5);
            sn = $urandom_range(0, 3);
            p  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) != 0);
            b  = ($urandom_range(0, 7) != 0);
            send_frame(d, p, a, b, 32'd7, sn, md);
            idle($urandom_range(4, 12));
        end

        // Transmitter loopback: fast bit rate, two stop bits, odd-mode parity
        for (int k = 0; k < 256; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send_frame(d, ~^d, 1'b1, 1'b1, 32'd4, 32'd2, 32'd2);
            idle($urandom_range(0, 3));
        end
        idle(10);
        rand_ready = 1'b0;
        tready = 1'b1;

        begin
            int t;
            t = 0;
            while ((q_byte.size() != 0 || q_evt.size() != 0) && t < 2000) begin
                @(negedge clk);
                t++;
            end
        end
        idle(50);
        chk("byte_queue_empty", q_byte.size(), 32'd0);
        chk("event_queue_empty", q_evt.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
